// File: rtl/reg_scoreboard_pkg.sv
// Shared widths, bus layouts and counter helpers for the register scoreboard.
package reg_scoreboard_pkg;

    localparam int SB_CNT_W    = 2;
    localparam int REG_IDX_W   = 5;
    localparam int DS_TO_SB_WD = 11;
    localparam int WB_TO_SB_WD = 7;
    localparam int ES_TO_SB_WD = 7;

    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = '1;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_CLR
    } cnt_op_e;

    // Bus layouts matching the widths above: {rj, rk, is_imm} and {valid, we, rd}.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rj;
        logic [REG_IDX_W-1:0] rk;
        logic                 isImm;
    } ds_to_sb_t;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [REG_IDX_W-1:0] rd;
    } wb_to_sb_t;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [REG_IDX_W-1:0] rd;
    } es_to_sb_t;

    // Saturating in both directions so a counter can never wrap.
    function automatic logic [SB_CNT_W-1:0] nextCount(input logic [SB_CNT_W-1:0] cur,
                                                      input cnt_op_e op);
        logic [SB_CNT_W-1:0] nxt;
        nxt = cur;
        case (op)
            CNT_CLR: nxt = '0;
            CNT_INC: nxt = (cur == SB_CNT_MAX) ? cur : cur + SB_CNT_W'(1);
            CNT_DEC: nxt = (cur == '0) ? cur : cur - SB_CNT_W'(1);
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/issue/writeback signals seen by the register scoreboard.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic                 issue_valid;
    logic                 issue_we;
    logic [REG_IDX_W-1:0] issue_rd;
    logic [REG_IDX_W-1:0] rj;
    logic [REG_IDX_W-1:0] rk;
    logic                 is_imm;
    logic                 wb_valid;
    logic                 wb_we;
    logic [REG_IDX_W-1:0] wb_rd;
    logic                 flush;
    logic                 is_stall;
    logic                 sb_err;

    modport master (
        output issue_valid, issue_we, issue_rd, rj, rk, is_imm,
        output wb_valid, wb_we, wb_rd, flush,
        input  is_stall, sb_err
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, rj, rk, is_imm,
        input  wb_valid, wb_we, wb_rd, flush,
        output is_stall, sb_err
    );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: one 2-bit pending-write counter with saturating inc/dec and clear.
module sb_counter
    import reg_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                clr_i,
    output logic [SB_CNT_W-1:0] cnt_o,
    output logic                underflow_o
);

    logic [SB_CNT_W-1:0] count_q;
    logic [SB_CNT_W-1:0] count_d;
    cnt_op_e             op;

    // Simultaneous inc and dec cancel; clear wins over both.
    always_comb begin
        op = CNT_HOLD;
        if (clr_i) begin
            op = CNT_CLR;
        end else if (inc_i && !dec_i) begin
            op = CNT_INC;
        end else if (dec_i && !inc_i) begin
            op = CNT_DEC;
        end
        count_d = nextCount(count_q, op);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign cnt_o       = count_q;
    assign underflow_o = (op == CNT_DEC) && (count_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters driving the decode stall.
// Define SB_WB_BYPASS_EN to let a same-cycle final retire release the stall.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    reg_scoreboard_if.slave sb
);

    ds_to_sb_t           dsBus;
    es_to_sb_t           esBus;
    wb_to_sb_t           wbBus;
    logic [SB_CNT_W-1:0] cnt [32];
    logic [31:1]         underflow;
    logic [31:0]         busyVec;
    logic                issueHit;
    logic                retireHit;
    logic                fullHit;
    logic                stall;
    logic                stickyErr_q;
    logic                stickyErr_d;

    assign dsBus = {sb.rj, sb.rk, sb.is_imm};
    assign esBus = {sb.issue_valid, sb.issue_we, sb.issue_rd};
    assign wbBus = {sb.wb_valid, sb.wb_we, sb.wb_rd};

    assign issueHit  = esBus.valid & esBus.we & (esBus.rd != '0) & ~stall;
    assign retireHit = wbBus.valid & wbBus.we & (wbBus.rd != '0);

    assign cnt[0] = '0;

    for (genvar i = 1; i < 32; i++) begin : gCnt
        sb_counter uCounter (
            .clk         (clk),
            .resetn      (resetn),
            .inc_i       (issueHit && (esBus.rd == REG_IDX_W'(i))),
            .dec_i       (retireHit && (wbBus.rd == REG_IDX_W'(i))),
            .clr_i       (sb.flush),
            .cnt_o       (cnt[i]),
            .underflow_o (underflow[i])
        );
    end

    // With bypass, a register whose only pending write retires this cycle is already free.
    always_comb begin
        busyVec = '0;
        for (int n = 1; n < 32; n++) begin
`ifdef SB_WB_BYPASS_EN
            busyVec[n] = (cnt[n] != '0) &&
                         !(retireHit && (wbBus.rd == REG_IDX_W'(n)) && (cnt[n] == SB_CNT_W'(1)));
`else
            busyVec[n] = (cnt[n] != '0);
`endif
        end
    end

    assign fullHit = esBus.we & (esBus.rd != '0) & (cnt[esBus.rd] == SB_CNT_MAX);
    assign stall   = busyVec[dsBus.rj] | (~dsBus.isImm & busyVec[dsBus.rk]) | fullHit;

    assign stickyErr_d = stickyErr_q | (|underflow);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stickyErr_q <= 1'b0;
        end else begin
            stickyErr_q <= stickyErr_d;
        end
    end

    assign sb.is_stall = stall;
    assign sb.sb_err   = stickyErr_q;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single core clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the ports issue_valid, issue_we and issue_rd, inputs of 1, 1 and 5 bits: the instruction leaving decode this cycle, whether it writes the register file, and its destination.
REQ-004 The block SHALL have the ports rj, rk and is_imm, inputs of 5, 5 and 1 bits: the source registers of the instruction in decode; is_imm=1 means rk is unused.
REQ-005 The block SHALL have the ports wb_valid, wb_we and wb_rd, inputs of 1, 1 and 5 bits: an instruction retiring in writeback this cycle.
REQ-006 The block SHALL have the port flush, input, 1 bit: pipeline cancel (exception or ertn); all in-flight writes are discarded.
REQ-007 The block SHALL have the port is_stall, output, 1 bit: decode must hold.
REQ-008 The block SHALL have the port sb_err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-009 The block SHALL hold one 2-bit pending counter per register r1..r31; r0 is never tracked and always reads not-busy.
REQ-010 Register n SHALL be busy when cnt[n] != 0.
REQ-011 is_stall SHALL be combinational from the current counters: busy(rj) | (~is_imm & busy(rk)) | (issue_we & cnt[issue_rd]==3 & issue_rd!=0).
REQ-012 The block SHALL count an issue when issue_valid & issue_we & issue_rd!=0 & ~is_stall.
REQ-013 The block SHALL count a retire when wb_valid & wb_we & wb_rd!=0.
REQ-014 On a counted issue alone, the block SHALL set cnt[issue_rd] to cnt+1 at the next edge.
REQ-015 On a counted retire alone, the block SHALL set cnt[wb_rd] to cnt-1 at the next edge.
REQ-016 On a same-cycle issue and retire to the same register, cnt SHALL be unchanged; to different registers, both updates SHALL apply.
REQ-017 A retire to a register with cnt==0 SHALL leave cnt at 0 and set sb_err.
REQ-018 A counted issue to a register with cnt==3 cannot occur (REQ-011); cnt SHALL never wrap.
REQ-019 flush SHALL have priority over same-cycle issue and retire: all counters become 0 at the next edge.
REQ-020 Latency: a counted issue SHALL be visible in is_stall in the next cycle; a retire SHALL clear busy in the next cycle (see REQ-025 for the bypass case).

Reset
REQ-021 On resetn=0, all counters SHALL clear to 0 and sb_err to 0 immediately and asynchronously.
REQ-022 While resetn=0, is_stall SHALL be 0 for any rj/rk.
REQ-023 Reset asserted mid-operation SHALL discard all pending counts; there SHALL be no recovery of in-flight state.

Configuration
REQ-024 Macro SB_WB_BYPASS_EN SHALL select write-back bypass.
REQ-025 With SB_WB_BYPASS_EN defined, busy(n) for the stall check SHALL use cnt[n] minus the same-cycle counted retire to n, so a register whose last pending write retires this cycle does not stall.
REQ-026 With SB_WB_BYPASS_EN undefined, busy SHALL use the registered cnt only, costing one extra stall cycle.

Structure
REQ-027 DEFINE.vh SHALL hold SB_CNT_W (=2) and the bus widths DS_TO_SB_WD (11), WB_TO_SB_WD (7) and ES_TO_SB_WD (7).
REQ-028 Top-level ports SHALL be packable as those buses.
REQ-029 One sub-module, sb_counter, SHALL implement a single 2-bit saturating inc/dec/clear counter; it SHALL be instantiated 31 times.

Verification
REQ-030 Reset, then issue rd=5; next cycle rj=5 -> is_stall=1; retire rd=5 -> is_stall=0 one cycle later (or the same cycle with SB_WB_BYPASS_EN).
REQ-031 Issue rd=0, then rj=0 -> is_stall stays 0 and cnt is untouched.
REQ-032 Three issues rd=7 with no retire -> cnt=3; a fourth issue with issue_we=1, rd=7 -> is_stall=1 and cnt stays 3; three retires -> cnt=0.
REQ-033 Simultaneous issue and retire rd=9 with cnt=1 -> cnt remains 1; with rk=9 and is_imm=1 -> is_stall=0.
REQ-034 Load cnt[3]=2 and cnt[4]=1, then flush together with an issue rd=3 -> all counters 0 next cycle.
REQ-035 Retire rd=12 with cnt=0 -> sb_err=1 and stays 1 until resetn=0; resetn pulse mid-run -> is_stall=0 immediately.
